// File: rtl/pipe_spawner.sv
// Pipe scheduler for FlappyBird: samples random_gen at each spawn, scrolls up to
// two pipes per frame tick and pulses score as a pipe passes the bird column.
module pipe_spawner #(
  parameter int SCREEN_W    = 640,
  parameter int PIPE_W      = 52,
  parameter int SPEED       = 2,
  parameter int SPAWN_TICKS = 180,
  parameter int GAP_MIN     = 100,
  parameter int RAND_SHIFT  = 1,
  parameter int BIRD_X      = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        clear,
  input  logic        tick,
  input  logic [7:0]  rand_in,
  output logic [1:0]  pipe_valid,
  output logic [10:0] pipe0_x,
  output logic [8:0]  pipe0_gap,
  output logic [10:0] pipe1_x,
  output logic [8:0]  pipe1_gap,
  output logic        score_pulse,
  output logic [7:0]  score,
  output logic        running
);

  // state  | meaning
  // S_IDLE | no game; slots empty, waiting for start
  // S_RUN  | pipes scroll, spawn and score on each tick
  // S_HALT | game over; everything frozen until clear
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam int CW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_TICKS - 1);
  localparam logic [10:0]   X_SPAWN  = 11'(SCREEN_W + PIPE_W);
  localparam logic [10:0]   SPEED_X  = 11'(SPEED);
  localparam logic [10:0]   BIRD_XX  = 11'(BIRD_X);

  state_t          r_state;
  logic [1:0]      r_valid;
  logic [10:0]     r_x [2];
  logic [8:0]      r_gap [2];
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_score;
  logic            r_pulse;
  logic            r_running;

  logic [1:0]      w_valid_mv;
  logic [10:0]     w_x_mv [2];
  logic [8:0]      w_gap_mv [2];
  logic [1:0]      w_cross;
  logic            w_spawn_due;
  logic            w_spawn_ok;
  logic            w_spawn_slot;
  logic [8:0]      w_gap_new;
  logic [8:0]      w_score_sum;

  // Post-move view of both slots; a spawn may reuse a slot retiring on the same tick.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_valid_mv[i] = r_valid[i] && (r_x[i] > SPEED_X);
      w_x_mv[i]     = w_valid_mv[i] ? (r_x[i] - SPEED_X) : '0;
      w_gap_mv[i]   = w_valid_mv[i] ? r_gap[i] : '0;
      w_cross[i]    = w_valid_mv[i] && (r_x[i] >= BIRD_XX) && (w_x_mv[i] < BIRD_XX);
    end
    w_spawn_due  = (r_cnt == CNT_LAST);
    w_spawn_ok   = w_spawn_due && !(&w_valid_mv);
    w_spawn_slot = w_valid_mv[0];
    w_gap_new    = 9'(GAP_MIN) + 9'(rand_in >> RAND_SHIFT);
    w_score_sum  = {1'b0, r_score} + {8'b0, w_cross[0]} + {8'b0, w_cross[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_x[i]   <= '0;
        r_gap[i] <= '0;
      end
      r_cnt     <= '0;
      r_score   <= '0;
      r_pulse   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pulse <= 1'b0;
          if (start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_score   <= '0;
            r_cnt     <= CNT_LAST;
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
            r_pulse   <= 1'b0;
          end else if (tick) begin
            for (int i = 0; i < 2; i++) begin
              r_valid[i] <= w_valid_mv[i];
              r_x[i]     <= w_x_mv[i];
              r_gap[i]   <= w_gap_mv[i];
            end
            if (w_spawn_ok) begin
              r_valid[w_spawn_slot] <= 1'b1;
              r_x[w_spawn_slot]     <= X_SPAWN;
              r_gap[w_spawn_slot]   <= w_gap_new;
            end
            r_score <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
            r_pulse <= |w_cross;
            if (!w_spawn_due)
              r_cnt <= r_cnt + 1'b1;
            else if (w_spawn_ok)
              r_cnt <= '0;
          end else begin
            r_pulse <= 1'b0;
          end
        end
        S_HALT: begin
          r_pulse <= 1'b0;
          if (clear) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            for (int i = 0; i < 2; i++) begin
              r_x[i]   <= '0;
              r_gap[i] <= '0;
            end
            r_score <= '0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_pulse   <= 1'b0;
        end
      endcase
    end
  end

  assign pipe_valid  = r_valid;
  assign pipe0_x     = r_x[0];
  assign pipe0_gap   = r_gap[0];
  assign pipe1_x     = r_x[1];
  assign pipe1_gap   = r_gap[1];
  assign score_pulse = r_pulse;
  assign score       = r_score;
  assign running     = r_running;

endmodule

// File: tb/tb_pipe_spawner.sv
// Bench for pipe_spawner: two instances (default and SPAWN_TICKS=100) driven by
// shared random stimulus and compared every cycle against a behavioural model.
module tb_pipe_spawner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, halt = 1'b0, clear = 1'b0, tick = 1'b0;
  logic [7:0] rand_in = 8'h00;

  logic [1:0]  pv  [2];
  logic [10:0] p0x [2];
  logic [8:0]  p0g [2];
  logic [10:0] p1x [2];
  logic [8:0]  p1g [2];
  logic        sp  [2];
  logic [7:0]  sc  [2];
  logic        run [2];

  always #5 clk = ~clk;

  pipe_spawner u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear(clear),
    .tick(tick), .rand_in(rand_in), .pipe_valid(pv[0]), .pipe0_x(p0x[0]),
    .pipe0_gap(p0g[0]), .pipe1_x(p1x[0]), .pipe1_gap(p1g[0]),
    .score_pulse(sp[0]), .score(sc[0]), .running(run[0]));

  pipe_spawner #(.SPAWN_TICKS(100)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clear(clear),
    .tick(tick), .rand_in(rand_in), .pipe_valid(pv[1]), .pipe0_x(p0x[1]),
    .pipe0_gap(p0g[1]), .pipe1_x(p1x[1]), .pipe1_gap(p1g[1]),
    .score_pulse(sp[1]), .score(sc[1]), .running(run[1]));

  // Reference model: mode 0=idle 1=run 2=halt, plain integers per instance/slot.
  int m_mode [2];
  int m_v    [2][2];
  int m_x    [2][2];
  int m_g    [2][2];
  int m_cnt  [2];
  int m_score[2];
  int m_pulse[2];

  int checks = 0;
  int failures = 0;
  int pulses_seen = 0;
  int cycle_no = 0;

  function automatic int st_of(input int d);
    return (d == 0) ? 180 : 100;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cycle_no, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_cnt[d] = 0; m_score[d] = 0; m_pulse[d] = 0;
      for (int i = 0; i < 2; i++) begin
        m_v[d][i] = 0; m_x[d][i] = 0; m_g[d][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int crossed;
      int nx;
      int free;
      m_pulse[d] = 0;
      case (m_mode[d])
        0: if (start) begin
             m_mode[d] = 1; m_score[d] = 0; m_cnt[d] = st_of(d) - 1;
           end
        1: if (halt) begin
             m_mode[d] = 2;
           end else if (tick) begin
             crossed = 0;
             for (int i = 0; i < 2; i++) begin
               if (m_v[d][i] != 0) begin
                 if (m_x[d][i] > 2) begin
                   nx = m_x[d][i] - 2;
                   if (m_x[d][i] >= 160 && nx < 160) crossed++;
                   m_x[d][i] = nx;
                 end else begin
                   m_v[d][i] = 0; m_x[d][i] = 0; m_g[d][i] = 0;
                 end
               end
             end
             m_score[d] = (m_score[d] + crossed > 255) ? 255 : m_score[d] + crossed;
             m_pulse[d] = (crossed > 0) ? 1 : 0;
             if (m_cnt[d] == st_of(d) - 1) begin
               free = (m_v[d][0] == 0) ? 0 : ((m_v[d][1] == 0) ? 1 : -1);
               if (free >= 0) begin
                 m_v[d][free] = 1;
                 m_x[d][free] = 640 + 52;
                 m_g[d][free] = 100 + (int'(rand_in) / 2);
                 m_cnt[d] = 0;
               end
             end else begin
               m_cnt[d]++;
             end
           end
        2: if (clear) begin
             m_mode[d] = 0; m_score[d] = 0;
             for (int i = 0; i < 2; i++) begin
               m_v[d][i] = 0; m_x[d][i] = 0; m_g[d][i] = 0;
             end
           end
        default: m_mode[d] = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("valid%0d", d), 32'(pv[d]), 32'(m_v[d][0] + 2 * m_v[d][1]));
      check($sformatf("pipe0_x%0d", d), 32'(p0x[d]), 32'(m_x[d][0]));
      check($sformatf("pipe0_gap%0d", d), 32'(p0g[d]), 32'(m_g[d][0]));
      check($sformatf("pipe1_x%0d", d), 32'(p1x[d]), 32'(m_x[d][1]));
      check($sformatf("pipe1_gap%0d", d), 32'(p1g[d]), 32'(m_g[d][1]));
      check($sformatf("pulse%0d", d), 32'(sp[d]), 32'(m_pulse[d]));
      check($sformatf("score%0d", d), 32'(sc[d]), 32'(m_score[d]));
      check($sformatf("running%0d", d), 32'(run[d]), (m_mode[d] == 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cycle_no++;
    model_step();
    #1;
    compare_all();
    if (sp[0] === 1'b1) pulses_seen++;
  endtask

  task automatic drive(input logic s, input logic h, input logic c, input logic t,
                       input logic [7:0] r);
    start = s; halt = h; clear = c; tick = t; rand_in = r;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    check("reset_valid", 32'(pv[0]), 32'd0);
    rst_n = 1'b1;

    drive(1, 0, 0, 0, 8'h00); cycle();
    drive(0, 0, 0, 1, 8'hFF); cycle();
    check("t1_valid", 32'(pv[0]), 32'd1);
    check("t1_x", 32'(p0x[0]), 32'd692);
    check("t1_gap", 32'(p0g[0]), 32'd227);
    drive(0, 0, 0, 1, 8'h00); cycle();
    check("t2_x", 32'(p0x[0]), 32'd690);
    check("t2_gap", 32'(p0g[0]), 32'd227);
    drive(0, 0, 0, 0, 8'h00); cycle();

    // Long uninterrupted run: spawns, scoring, retires and deferred spawns.
    repeat (1200) begin
      drive(1'($urandom_range(1, 0)), 0, 1'($urandom_range(1, 0)),
            $urandom_range(3, 0) != 0, 8'($urandom));
      cycle();
    end

    repeat (2000) begin
      drive($urandom_range(9, 0) == 0, $urandom_range(99, 0) == 0,
            $urandom_range(9, 0) == 0, $urandom_range(3, 0) != 0, 8'($urandom));
      cycle();
    end

    drive(0, 1, 0, 0, 8'h00); cycle();
    drive(0, 0, 1, 0, 8'h00); cycle();
    drive(1, 0, 0, 0, 8'h00); cycle();
    repeat (5) begin drive(0, 0, 0, 1, 8'($urandom)); cycle(); end
    drive(0, 1, 0, 1, 8'h55); cycle();
    check("halt_running", 32'(run[0]), 32'd0);
    check("halt_x", 32'(p0x[0]), 32'd684);
    repeat (3) begin drive(1, 0, 0, 1, 8'($urandom)); cycle(); end
    drive(0, 0, 1, 0, 8'h00); cycle();
    check("clear_valid", 32'(pv[0]), 32'd0);
    check("clear_score", 32'(sc[0]), 32'd0);

    drive(1, 0, 0, 0, 8'h00); cycle();
    repeat (10) begin drive(0, 0, 0, 1, 8'($urandom)); cycle(); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_valid", 32'(pv[1]), 32'd0);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 1, 8'h00);
    repeat (3) cycle();

    check("pulse_seen", (pulses_seen > 0) ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
